// File: rtl/mod_counter_ctrl_pkg.sv
// Shared encodings for the modulo counter sequencer.
// State values are visible on the state port, so they are fixed here.
package mod_counter_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mod_counter_ctrl_if.sv
// Control and status bundle between the sequencer and its host.
// The master drives requests and configuration; the slave reports status.
interface mod_counter_ctrl_if #(
    parameter int K = 3,
    parameter int R = 4
);
    import mod_counter_pkg::*;

    logic         start;
    logic         pause;
    logic         stop;
    logic [K-1:0] cfg_last;
    logic [R-1:0] cfg_reps;
    logic [K-1:0] counter;
    logic         busy;
    logic         wrap;
    logic         done;
    state_t       state;

    modport master (
        output start, pause, stop, cfg_last, cfg_reps,
        input  counter, busy, wrap, done, state
    );

    modport slave (
        input  start, pause, stop, cfg_last, cfg_reps,
        output counter, busy, wrap, done, state
    );

endinterface

// File: rtl/mod_counter_ctrl_core.sv
// Modulo count register with terminal-count compare.
// clr has priority over en; a counting edge at terminal count rolls to 0.
module mod_counter_core #(
    parameter int K = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         en,
    input  logic         clr,
    input  logic [K-1:0] last,
    output logic [K-1:0] counter,
    output logic         tc
);

    assign tc = (counter == last);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            counter <= '0;
        end else if (clr) begin
            counter <= '0;
        end else if (en) begin
            counter <= tc ? '0 : counter + K'(1);
        end
    end

endmodule

// File: rtl/mod_counter_ctrl.sv
// Start/pause/stop/repeat sequencer around a programmable modulo counter.
// Reset asserts asynchronously and releases through a two-flop synchroniser.
module mod_counter_ctrl
    import mod_counter_pkg::*;
#(
    parameter int K = 3,
    parameter int N = 8,
    parameter int R = 4
) (
    input logic               CLK,
    input logic               RST,
    mod_counter_ctrl_if.slave bus
);

    localparam logic [K-1:0] LAST_MAX = K'(N - 1);

    logic [1:0]   rst_sync;
    logic         rst_s;
    state_t       state_q;
    state_t       state_d;
    logic [K-1:0] last_q;
    logic [K-1:0] last_in;
    logic [R-1:0] reps_q;
    logic [R-1:0] rep_q;
    logic [R-1:0] rep_inc;
    logic [K-1:0] count;
    logic         tc;
    logic         en;
    logic         clr;
    logic         load;
    logic         wrap_d;
    logic         wrap_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_s = rst_sync[1];

    // Clamp only exists when the modulus does not fill the counter width.
    if (N < (1 << K)) begin : g_clamp
        assign last_in = (bus.cfg_last > LAST_MAX) ? LAST_MAX : bus.cfg_last;
    end else begin : g_noclamp
        assign last_in = bus.cfg_last;
    end

    mod_counter_core #(
        .K (K)
    ) u_core (
        .CLK     (CLK),
        .RST     (rst_s),
        .en      (en),
        .clr     (clr),
        .last    (last_q),
        .counter (count),
        .tc      (tc)
    );

    assign rep_inc = rep_q + R'(1);

    always_comb begin
        state_d = state_q;
        en      = 1'b0;
        clr     = 1'b0;
        load    = 1'b0;
        wrap_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                clr = 1'b1;
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                end else if (bus.pause) begin
                    state_d = ST_HOLD;
                end else begin
                    en = 1'b1;
                    if (tc) begin
                        wrap_d = 1'b1;
                        if (reps_q != '0 && rep_inc == reps_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (bus.stop) begin
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                end else if (!bus.pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                clr     = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_s) begin
        if (!rst_s) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_MAX;
            reps_q  <= '0;
            rep_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= wrap_d;
            if (load) begin
                last_q <= last_in;
                reps_q <= bus.cfg_reps;
                rep_q  <= '0;
            end else if (wrap_d) begin
                rep_q <= rep_inc;
            end
        end
    end

    assign bus.counter = count;
    assign bus.busy    = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign bus.wrap    = wrap_q;
    assign bus.done    = (state_q == ST_DONE);
    assign bus.state   = state_q;

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Bench for mod_counter_ctrl: directed scenarios plus random traffic,
// compared every cycle against an arithmetic model of the count sequence.
module tb_mod_counter_ctrl;

    localparam int K = 3;
    localparam int N = 6;
    localparam int R = 4;

    logic CLK = 1'b0;
    logic RST;

    mod_counter_ctrl_if #(.K(K), .R(R)) bus ();

    mod_counter_ctrl #(
        .K (K),
        .N (N),
        .R (R)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: mode 0..3, count edges taken since start, latched config.
    int m_mode  = 0;
    int m_steps = 0;
    int m_last  = N - 1;
    int m_reps  = 0;
    int m_rel   = 0;
    bit m_wrap  = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic m_reset();
        m_mode  = 0;
        m_steps = 0;
        m_last  = N - 1;
        m_reps  = 0;
        m_rel   = 0;
        m_wrap  = 1'b0;
    endtask

    function automatic int exp_cnt();
        if (m_mode == 1 || m_mode == 2) return m_steps % (m_last + 1);
        return 0;
    endfunction

    always @(negedge RST) m_reset();

    always @(posedge CLK) begin
        if (!RST) begin
            m_reset();
        end else if (m_rel < 2) begin
            m_rel++;
        end else begin
            m_wrap = 1'b0;
            case (m_mode)
                0: if (bus.start) begin
                    m_last  = (int'(bus.cfg_last) > N - 1) ? N - 1 : int'(bus.cfg_last);
                    m_reps  = int'(bus.cfg_reps);
                    m_steps = 0;
                    m_mode  = 1;
                end
                1: begin
                    if (bus.stop) m_mode = 0;
                    else if (bus.pause) m_mode = 2;
                    else begin
                        m_steps++;
                        if (m_steps % (m_last + 1) == 0) begin
                            m_wrap = 1'b1;
                            if (m_reps != 0 && m_steps == m_reps * (m_last + 1))
                                m_mode = 3;
                        end
                    end
                end
                2: begin
                    if (bus.stop) m_mode = 0;
                    else if (!bus.pause) m_mode = 1;
                end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge CLK) begin
        check("counter", int'(bus.counter), exp_cnt());
        check("state", int'(bus.state), m_mode);
        check("busy", int'(bus.busy), int'(m_mode == 1 || m_mode == 2));
        check("wrap", int'(bus.wrap), int'(m_wrap));
        check("done", int'(bus.done), int'(m_mode == 3));
    end

    int nw, nd, nb, mx;

    initial begin
        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        bus.stop     = 1'b0;
        bus.cfg_last = '0;
        bus.cfg_reps = '0;
        RST = 1'b1;
        #1 RST = 1'b0;
        tick(3);
        check("rst_counter", int'(bus.counter), 0);
        check("rst_state", int'(bus.state), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_wrap", int'(bus.wrap), 0);
        check("rst_done", int'(bus.done), 0);
        RST = 1'b1;
        tick(3);

        // single shot
        bus.cfg_last = 3'd2;
        bus.cfg_reps = 4'd1;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check("ss_c0", int'(bus.counter), 0);
        check("ss_run", int'(bus.state), 1);
        tick(1);
        check("ss_c1", int'(bus.counter), 1);
        tick(1);
        check("ss_c2", int'(bus.counter), 2);
        tick(1);
        check("ss_c3", int'(bus.counter), 0);
        check("ss_wrap", int'(bus.wrap), 1);
        check("ss_done", int'(bus.done), 1);
        check("ss_st_done", int'(bus.state), 3);
        tick(1);
        check("ss_idle", int'(bus.state), 0);
        check("ss_done_off", int'(bus.done), 0);

        // continuous, cfg_last clamped to 5
        bus.cfg_last = 3'd7;
        bus.cfg_reps = 4'd0;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        nw = 0; nd = 0; nb = 0;
        repeat (40) begin
            tick(1);
            nw += int'(bus.wrap);
            nd += int'(bus.done);
            nb += int'(bus.busy);
        end
        check("cont_wraps", nw, 6);
        check("cont_done", nd, 0);
        check("cont_busy", nb, 40);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        check("cont_stop", int'(bus.state), 0);

        // clamp and repeat
        bus.cfg_last = 3'd7;
        bus.cfg_reps = 4'd3;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        mx = 0;
        repeat (17) begin
            tick(1);
            if (int'(bus.counter) > mx) mx = int'(bus.counter);
        end
        check("clamp_run17", int'(bus.state), 1);
        check("clamp_max", mx, 5);
        tick(1);
        check("clamp_done18", int'(bus.done), 1);
        tick(1);
        check("clamp_idle", int'(bus.state), 0);

        // pause at counter 3
        bus.cfg_last = 3'd7;
        bus.cfg_reps = 4'd0;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(3);
        check("pause_pre", int'(bus.counter), 3);
        bus.pause = 1'b1;
        repeat (4) begin
            tick(1);
            check("pause_hold_st", int'(bus.state), 2);
            check("pause_hold_c", int'(bus.counter), 3);
        end
        bus.pause = 1'b0;
        tick(1);
        check("pause_rel_st", int'(bus.state), 1);
        check("pause_rel_c", int'(bus.counter), 3);
        tick(1);
        check("pause_next_c", int'(bus.counter), 4);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;

        // stop at terminal count
        bus.cfg_last = 3'd2;
        bus.cfg_reps = 4'd1;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(2);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;
        check("stop_tc_st", int'(bus.state), 0);
        check("stop_tc_c", int'(bus.counter), 0);
        check("stop_tc_wrap", int'(bus.wrap), 0);
        check("stop_tc_done", int'(bus.done), 0);

        // start during RUN is ignored
        bus.cfg_last = 3'd3;
        bus.cfg_reps = 4'd2;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(1);
        bus.cfg_last = 3'd1;
        bus.cfg_reps = 4'd1;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        check("ign_start_c", int'(bus.counter), 2);
        tick(6);
        check("ign_start_done", int'(bus.state), 3);
        tick(1);

        // pause at terminal count defers the wrap
        bus.cfg_last = 3'd1;
        bus.cfg_reps = 4'd0;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(1);
        bus.pause = 1'b1;
        tick(1);
        check("ptc_hold_wrap", int'(bus.wrap), 0);
        bus.pause = 1'b0;
        tick(1);
        check("ptc_res_c", int'(bus.counter), 1);
        tick(1);
        check("ptc_wrap", int'(bus.wrap), 1);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;

        // last = 0 wraps every cycle
        bus.cfg_last = 3'd0;
        bus.cfg_reps = 4'd0;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        nw = 0;
        repeat (5) begin
            tick(1);
            nw += int'(bus.wrap);
        end
        check("last0_wraps", nw, 5);
        bus.stop = 1'b1;
        tick(1);
        bus.stop = 1'b0;

        // reset mid-count
        bus.cfg_last = 3'd7;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(5);
        check("mid_c5", int'(bus.counter), 5);
        #2 RST = 1'b0;
        #1;
        check("mid_rst_c", int'(bus.counter), 0);
        check("mid_rst_st", int'(bus.state), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        tick(1);
        RST = 1'b1;
        tick(3);

        // random traffic
        repeat (3000) begin
            tick(1);
            bus.start    = ($urandom % 4) == 0;
            bus.pause    = ($urandom % 6) == 0;
            bus.stop     = ($urandom % 30) == 0;
            bus.cfg_last = K'($urandom);
            bus.cfg_reps = R'($urandom_range(0, 3));
            if (!RST) begin
                RST = 1'b1;
            end else if (($urandom % 600) == 0) begin
                #2 RST = 1'b0;
            end
        end
        tick(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
